// File: rtl/game_button_debouncer_if.sv
// game_button_debouncer_if: raw button pins in, debounced level and press/release pulses out
interface game_button_debouncer_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_state;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  modport master (output btn_raw, input btn_state, btn_press, btn_release);
  modport slave (input btn_raw, output btn_state, btn_press, btn_release);
endinterface

// File: rtl/game_button_debouncer.sv
// game_button_debouncer: per-channel sync, debounce and press/release pulses; define GAME_BTN_AUTOREPEAT_EN for hold-to-repeat presses
module game_button_debouncer #(
  parameter int NUM_BTN = 4,
  parameter int DEBOUNCE_CYCLES = 25000,
  parameter int ACTIVE_LOW = 0,
  parameter int REPEAT_DELAY = 2500000,
  parameter int REPEAT_PERIOD = 500000
) (
  input logic clk_5mhz,
  input logic rst,
  game_button_debouncer_if.slave btn
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic REL_LVL = (ACTIVE_LOW != 0);
`ifdef GAME_BTN_AUTOREPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);
`endif
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be within 2..2^20");
  end
  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY must be >= 2 and REPEAT_PERIOD >= 1");
  end
  typedef enum logic [1:0] {
    IDLE,
    PRESSED
`ifdef GAME_BTN_AUTOREPEAT_EN
    , REPEATING
`endif
  } btn_fsm_t;
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic meta_q, sync_q, sync, accept;
    logic state_q, state_d, press_q, press_d, rel_q, rel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    btn_fsm_t fsm_q, fsm_d;
    assign sync = sync_q ^ REL_LVL;
    // accept only after DEBOUNCE_CYCLES consecutive disagreeing samples; any agreement restarts the count
    assign accept = (sync != state_q) && (cnt_q == CNT_LAST);
    assign state_d = accept ? sync : state_q;
    assign cnt_d = (sync == state_q || accept) ? '0 : cnt_q + 1'b1;
    assign btn.btn_state[i] = state_q;
    assign btn.btn_press[i] = press_q;
    assign btn.btn_release[i] = rel_q;
`ifdef GAME_BTN_AUTOREPEAT_EN
    logic [HW-1:0] hold_q, hold_d;
    always_ff @(posedge clk_5mhz or posedge rst) begin
      if (rst) hold_q <= '0;
      else hold_q <= hold_d;
    end
    always_comb begin
      fsm_d = fsm_q;
      press_d = 1'b0;
      rel_d = 1'b0;
      hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
      case (fsm_q)
        IDLE: begin
          hold_d = '0;
          if (accept && sync) begin
            fsm_d = PRESSED;
            press_d = 1'b1;
          end
        end
        PRESSED:
          if (accept && !sync) begin
            fsm_d = IDLE;
            rel_d = 1'b1;
          end else if (hold_q == DELAY_LAST) begin
            fsm_d = REPEATING;
            press_d = 1'b1;
            hold_d = '0;
          end
        REPEATING:
          if (accept && !sync) begin
            fsm_d = IDLE;
            rel_d = 1'b1;
          end else if (hold_q == PER_LAST) begin
            press_d = 1'b1;
            hold_d = '0;
          end
        default: fsm_d = IDLE;
      endcase
    end
`else
    always_comb begin
      fsm_d = fsm_q;
      press_d = 1'b0;
      rel_d = 1'b0;
      case (fsm_q)
        IDLE:
          if (accept && sync) begin
            fsm_d = PRESSED;
            press_d = 1'b1;
          end
        PRESSED:
          if (accept && !sync) begin
            fsm_d = IDLE;
            rel_d = 1'b1;
          end
        default: fsm_d = IDLE;
      endcase
    end
`endif
    // synchronizer resets to the released pin level so an idle button never fires after reset
    always_ff @(posedge clk_5mhz or posedge rst) begin
      if (rst) begin
        meta_q <= REL_LVL;
        sync_q <= REL_LVL;
        state_q <= 1'b0;
        press_q <= 1'b0;
        rel_q <= 1'b0;
        cnt_q <= '0;
        fsm_q <= IDLE;
      end else begin
        meta_q <= btn.btn_raw[i];
        sync_q <= meta_q;
        state_q <= state_d;
        press_q <= press_d;
        rel_q <= rel_d;
        cnt_q <= cnt_d;
        fsm_q <= fsm_d;
      end
    end
  end
endmodule

// File: tb/tb_game_button_debouncer.sv
// tb_game_button_debouncer: scoreboard bench; expected press/release events are queued with their cycle stamps
module tb_game_button_debouncer;
  localparam int NB = 4;
  logic clk_5mhz = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int errors = 0;
  int checks = 0;
  typedef struct {
    int unsigned cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] state;
  } ev_t;
  ev_t sbq[$];
  game_button_debouncer_if #(.NUM_BTN(NB)) bif ();
  game_button_debouncer #(
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(8),
    .ACTIVE_LOW(0),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk_5mhz(clk_5mhz),
    .rst(rst),
    .btn(bif)
  );
  always #100 clk_5mhz = ~clk_5mhz;
  always @(posedge clk_5mhz) cyc <= cyc + 1;
  // monitor: every output event must match the head of the scoreboard exactly
  always @(posedge clk_5mhz) begin
    ev_t e;
    #1;
    if (!rst) begin
      if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        e = sbq.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event: nothing seen by cycle %0d, required press=%b release=%b at cycle %0d", cyc, e.press, e.rel, e.cyc);
      end
      if (|bif.btn_press || |bif.btn_release) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: cycle %0d press=%b release=%b, required no event", cyc, bif.btn_press, bif.btn_release);
        end else begin
          e = sbq.pop_front();
          if (e.cyc !== cyc || bif.btn_press !== e.press || bif.btn_release !== e.rel || bif.btn_state !== e.state) begin
            errors++;
            $display("FAIL event: got cycle %0d press=%b release=%b state=%b, required cycle %0d press=%b release=%b state=%b",
                     cyc, bif.btn_press, bif.btn_release, bif.btn_state, e.cyc, e.press, e.rel, e.state);
          end
        end
      end
    end
  end
  task automatic push(input int unsigned at, input logic [3:0] p, input logic [3:0] r, input logic [3:0] s);
    ev_t e;
    e.cyc = at;
    e.press = p;
    e.rel = r;
    e.state = s;
    sbq.push_back(e);
  endtask
  task automatic wait_drain(input int limit, output int pending);
    int n = 0;
    while (sbq.size() != 0 && n < limit) begin
      @(negedge clk_5mhz);
      n++;
    end
    pending = sbq.size();
    sbq.delete();
  endtask
  task automatic test_reset();
    bif.btn_raw = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk_5mhz);
    checks += 3;
    if (bif.btn_state !== 4'b0) begin errors++; $display("FAIL reset_state: got %b, required 0000", bif.btn_state); end
    if (bif.btn_press !== 4'b0) begin errors++; $display("FAIL reset_press: got %b, required 0000", bif.btn_press); end
    if (bif.btn_release !== 4'b0) begin errors++; $display("FAIL reset_release: got %b, required 0000", bif.btn_release); end
    rst = 1'b0;
    repeat (12) @(negedge clk_5mhz);
    checks++;
    if (bif.btn_state !== 4'b0) begin errors++; $display("FAIL post_reset_idle: got %b, required 0000", bif.btn_state); end
  endtask
  task automatic test_single_press();
    int pending;
    bif.btn_raw = 4'b0001;
    push(cyc + 10, 4'b0001, 4'b0000, 4'b0001);
    wait_drain(30, pending);
    checks++;
    if (pending !== 0) begin errors++; $display("FAIL single_press_timeout: %0d pending, required 0", pending); end
    @(negedge clk_5mhz);
    checks++;
    if (bif.btn_press !== 4'b0 || bif.btn_state !== 4'b0001) begin
      errors++;
      $display("FAIL single_press_pulse: press=%b state=%b, required press=0000 state=0001", bif.btn_press, bif.btn_state);
    end
    bif.btn_raw = 4'b0000;
    push(cyc + 10, 4'b0000, 4'b0001, 4'b0000);
    wait_drain(30, pending);
    checks++;
    if (pending !== 0) begin errors++; $display("FAIL single_release_timeout: %0d pending, required 0", pending); end
  endtask
  task automatic test_glitch();
    for (int k = 0; k < 3; k++) begin
      bif.btn_raw = 4'b0010;
      repeat (5) @(negedge clk_5mhz);
      bif.btn_raw = 4'b0000;
      repeat (2) @(negedge clk_5mhz);
    end
    // one short of acceptance, a single-cycle dip, then one short again: the count must restart
    bif.btn_raw = 4'b0010;
    repeat (7) @(negedge clk_5mhz);
    bif.btn_raw = 4'b0000;
    @(negedge clk_5mhz);
    bif.btn_raw = 4'b0010;
    repeat (7) @(negedge clk_5mhz);
    bif.btn_raw = 4'b0000;
    repeat (20) @(negedge clk_5mhz);
    checks++;
    if (bif.btn_state !== 4'b0) begin errors++; $display("FAIL glitch_state: got %b, required 0000", bif.btn_state); end
  endtask
  task automatic test_min_pulse();
    int pending;
    int unsigned c0 = cyc;
    bif.btn_raw = 4'b0010;
    push(c0 + 10, 4'b0010, 4'b0000, 4'b0010);
    push(c0 + 18, 4'b0000, 4'b0010, 4'b0000);
    repeat (8) @(negedge clk_5mhz);
    bif.btn_raw = 4'b0000;
    wait_drain(30, pending);
    checks++;
    if (pending !== 0) begin errors++; $display("FAIL min_pulse_timeout: %0d pending, required 0", pending); end
  endtask
  task automatic test_simultaneous();
    int pending;
    bif.btn_raw = 4'b1010;
    push(cyc + 10, 4'b1010, 4'b0000, 4'b1010);
    wait_drain(30, pending);
    checks++;
    if (pending !== 0) begin errors++; $display("FAIL simul_press_timeout: %0d pending, required 0", pending); end
    @(negedge clk_5mhz);
    bif.btn_raw = 4'b0000;
    push(cyc + 10, 4'b0000, 4'b1010, 4'b0000);
    wait_drain(30, pending);
    checks++;
    if (pending !== 0) begin errors++; $display("FAIL simul_release_timeout: %0d pending, required 0", pending); end
  endtask
  task automatic test_reset_held();
    int pending;
    bif.btn_raw = 4'b0100;
    push(cyc + 10, 4'b0100, 4'b0000, 4'b0100);
    wait_drain(30, pending);
    checks++;
    if (pending !== 0) begin errors++; $display("FAIL held_press_timeout: %0d pending, required 0", pending); end
    @(negedge clk_5mhz);
    #20 rst = 1'b1;
    #1;
    checks++;
    if (bif.btn_state !== 4'b0 || bif.btn_press !== 4'b0 || bif.btn_release !== 4'b0) begin
      errors++;
      $display("FAIL async_reset: state=%b press=%b release=%b, required all 0000", bif.btn_state, bif.btn_press, bif.btn_release);
    end
    repeat (3) @(negedge clk_5mhz);
    rst = 1'b0;
    push(cyc + 10, 4'b0100, 4'b0000, 4'b0100);
    wait_drain(30, pending);
    checks++;
    if (pending !== 0) begin errors++; $display("FAIL repress_timeout: %0d pending, required 0", pending); end
    @(negedge clk_5mhz);
    bif.btn_raw = 4'b0000;
    push(cyc + 10, 4'b0000, 4'b0100, 4'b0000);
    wait_drain(30, pending);
    checks++;
    if (pending !== 0) begin errors++; $display("FAIL held_release_timeout: %0d pending, required 0", pending); end
  endtask
  task automatic test_autorepeat();
    int pending;
    int unsigned c0 = cyc;
    bif.btn_raw = 4'b1000;
    push(c0 + 10, 4'b1000, 4'b0000, 4'b1000);
`ifdef GAME_BTN_AUTOREPEAT_EN
    for (int k = 30; k < 70; k += 5) push(c0 + k, 4'b1000, 4'b0000, 4'b1000);
`endif
    push(c0 + 70, 4'b0000, 4'b1000, 4'b0000);
    repeat (60) @(negedge clk_5mhz);
    bif.btn_raw = 4'b0000;
    wait_drain(40, pending);
    checks++;
    if (pending !== 0) begin errors++; $display("FAIL autorepeat_timeout: %0d pending, required 0", pending); end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_min_pulse();
    test_simultaneous();
    test_reset_held();
    test_autorepeat();
    repeat (5) @(negedge clk_5mhz);
    checks++;
    if (bif.btn_state !== 4'b0) begin errors++; $display("FAIL final_state: got %b, required 0000", bif.btn_state); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
